// File: rtl/db_scan_ctrl.sv
// db_scan_ctrl: 4-channel switch debouncer sharing one round-robin-arbitrated countdown timer; DB_SCAN_FALL_TICK_EN adds db_fall
module db_scan_ctrl #(
  parameter int N = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] db_level,
  output logic [3:0] db_tick,
`ifdef DB_SCAN_FALL_TICK_EN
  output logic [3:0] db_fall,
`endif
  output logic       busy,
  output logic [1:0] owner
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state, state_n;
  logic [3:0] s1, sw_s, req, level_n, tick_n;
  logic [N-1:0] timer, timer_n, dec;
  logic busy_n, found;
  logic [1:0] owner_n, ptr, ptr_n, gnt;
`ifdef DB_SCAN_FALL_TICK_EN
  logic [3:0] fall_n;
`endif
  assign req = sw_s ^ db_level;
  assign dec = timer - N'(1);
  // two-flop synchronizer for the raw switch inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= '0;
      sw_s <= '0;
    end else begin
      s1   <= sw;
      sw_s <= s1;
    end
  end
  // round-robin pick: first requester at or after ptr, wrapping
  always_comb begin
    gnt   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        gnt   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end
  // arbiter next state: grant in IDLE, count/abort/finish in COUNT
  always_comb begin
    state_n = state;
    timer_n = timer;
    level_n = db_level;
    tick_n  = '0;
    busy_n  = busy;
    owner_n = owner;
    ptr_n   = ptr;
`ifdef DB_SCAN_FALL_TICK_EN
    fall_n  = '0;
`endif
    if (state == IDLE) begin
      if (found) begin
        state_n = COUNT;
        timer_n = '1;
        owner_n = gnt;
        busy_n  = 1'b1;
      end
    end else if (!req[owner] || dec == '0) begin
      state_n = IDLE;
      timer_n = '0;
      busy_n  = 1'b0;
      ptr_n   = owner + 2'd1;
      if (req[owner]) begin
        level_n[owner] = ~db_level[owner];
        tick_n[owner]  = ~db_level[owner];
`ifdef DB_SCAN_FALL_TICK_EN
        fall_n[owner]  = db_level[owner];
`endif
      end
    end else begin
      timer_n = dec;
    end
  end
  // arbiter state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // registered timer, pointer and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer    <= '0;
      ptr      <= '0;
      db_level <= '0;
      db_tick  <= '0;
      busy     <= 1'b0;
      owner    <= '0;
`ifdef DB_SCAN_FALL_TICK_EN
      db_fall  <= '0;
`endif
    end else begin
      timer    <= timer_n;
      ptr      <= ptr_n;
      db_level <= level_n;
      db_tick  <= tick_n;
      busy     <= busy_n;
      owner    <= owner_n;
`ifdef DB_SCAN_FALL_TICK_EN
      db_fall  <= fall_n;
`endif
    end
  end
endmodule

// File: tb/tb_db_scan_ctrl.sv
// tb_db_scan_ctrl: directed bench with a per-channel behavioural model for db_scan_ctrl (N=4)
module tb_db_scan_ctrl;
  localparam int N = 4;
  localparam int LAT = 2**N - 1;
  logic clk = 0, rst;
  logic [3:0] sw, db_level, db_tick;
  logic busy;
  logic [1:0] owner;
`ifdef DB_SCAN_FALL_TICK_EN
  logic [3:0] db_fall;
`endif
  int vectors = 0, miscompares = 0;
  logic chk_en = 0;
  db_scan_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .sw(sw), .db_level(db_level), .db_tick(db_tick),
`ifdef DB_SCAN_FALL_TICK_EN
    .db_fall(db_fall),
`endif
    .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // model: sw delayed two edges; owner counts elapsed edges up to LAT
  logic [3:0] m_s1 = 0, m_s2 = 0, m_lvl = 0, m_tick = 0, m_fall = 0;
  logic m_busy = 0;
  int m_own = 0, m_ptr = 0, m_el = 0;
  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_tick = 0; m_fall = 0;
      m_busy = 0; m_own = 0; m_ptr = 0; m_el = 0;
    end else begin
      m_tick = 0;
      m_fall = 0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++)
          if (!m_busy && m_s2[(m_ptr + k) % 4] != m_lvl[(m_ptr + k) % 4]) begin
            m_busy = 1;
            m_own = (m_ptr + k) % 4;
            m_el = 0;
          end
      end else if (m_s2[m_own] == m_lvl[m_own]) begin
        m_busy = 0;
        m_ptr = (m_own + 1) % 4;
      end else begin
        m_el++;
        if (m_el == LAT) begin
          m_lvl[m_own] = !m_lvl[m_own];
          m_tick[m_own] = m_lvl[m_own];
          m_fall[m_own] = !m_lvl[m_own];
          m_busy = 0;
          m_ptr = (m_own + 1) % 4;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("db_level", 32'(db_level), 32'(m_lvl));
      check("db_tick", 32'(db_tick), 32'(m_tick));
      check("busy", 32'(busy), 32'(m_busy));
      check("owner", 32'(owner), 32'(m_own));
      check("tick_onehot", 32'($countones(db_tick) <= 1), 32'd1);
`ifdef DB_SCAN_FALL_TICK_EN
      check("db_fall", 32'(db_fall), 32'(m_fall));
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_busy(input logic v, output int n);
    n = 0;
    while (busy !== v && n < 20) begin
      step();
      n++;
    end
  endtask
  int n, nt, nf;
  int tick_t [4];
  initial begin
    rst = 0;
    sw = 4'hF;
    step();
    chk_en = 1;
    step();
    check("rst_outputs", {db_level, db_tick, 3'b0, busy, 2'b0, owner}, 0);
    rst = 1;
    wait_busy(1, n);
    check("rst_release_to_busy", n, 3);
    check("first_owner", 32'(owner), 0);
    nt = 0;
    for (int t = 4; t <= 80; t++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (db_tick[i]) begin
          tick_t[i] = t;
          nt++;
        end
    end
    check("rr_tick_count", nt, 4);
    for (int i = 0; i < 4; i++) check("rr_tick_time", tick_t[i], 18 + 16 * i);
    check("all_high", 32'(db_level), 32'hF);
    sw = 4'h0;
    for (int t = 0; t < 80; t++) step();
    check("all_low", 32'(db_level), 0);
    sw = 4'b0100;
    wait_busy(1, n);
    check("ch2_grant_delay", n, 3);
    check("ch2_owner", 32'(owner), 2);
    n = 0;
    while (!db_tick[2] && n < 30) begin
      step();
      n++;
    end
    check("ch2_latency", n, LAT);
    check("ch2_busy_falls", 32'(busy), 0);
    check("ch2_level", 32'(db_level), 32'b0100);
    step();
    check("ch2_tick_one_cycle", 32'(db_tick), 0);
    sw = 4'b0110;
    wait_busy(1, n);
    check("ch1_grant_delay", n, 3);
    check("ch1_owner", 32'(owner), 1);
    for (int t = 0; t < 5; t++) step();
    sw = 4'b0100;
    wait_busy(0, n);
    check("ch1_abort_delay", n, 3);
    check("ch1_abort_level", 32'(db_level), 32'b0100);
    check("ch1_abort_tick", 32'(db_tick), 0);
    sw = 4'hF;
    wait_busy(1, n);
    check("ptr_after_abort_owner", 32'(owner), 3);
    for (int t = 0; t < 8; t++) step();
    rst = 0;
    step();
    check("midcount_rst", {db_level, db_tick, 3'b0, busy}, 0);
    rst = 1;
    wait_busy(1, n);
    check("post_rst_grant_delay", n, 3);
    check("post_rst_owner", 32'(owner), 0);
    for (int t = 0; t < 70; t++) step();
    check("all_high_again", 32'(db_level), 32'hF);
    sw = 4'h0;
    nt = 0;
    nf = 0;
    for (int t = 0; t < 80; t++) begin
      step();
      nt += $countones(db_tick);
`ifdef DB_SCAN_FALL_TICK_EN
      nf += int'(db_fall[0]);
`endif
    end
    check("fall_no_ticks", nt, 0);
`ifdef DB_SCAN_FALL_TICK_EN
    check("fall0_pulses", nf, 1);
`endif
    check("final_low", 32'(db_level), 0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/db_scan_ctrl.md
DB_SCAN_CTRL -- requirements
Module: db_scan_ctrl

Interface
REQ-001 SHALL have parameter N, default 21, the width of the shared debounce countdown timer.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port sw  input  4  raw, asynchronous, bouncy switch inputs, one per channel.
REQ-005 SHALL have port db_level  output  4  debounced level per channel, registered.
REQ-006 SHALL have port db_tick  output  4  one-cycle pulse per channel on a debounced 0->1 transition, registered.
REQ-007 SHALL have port busy  output  1  high while a channel owns the shared timer, registered.
REQ-008 SHALL have port owner  output  2  index of the channel owning or last owning the timer, registered.

Function
REQ-009 SHALL pass each sw bit through a 2-flop synchronizer (sw_s); sw_s lags sw by 2 cycles.
REQ-010 Channel i SHALL request when sw_s[i] != db_level[i]; the request is level-based, so a change that reverts before grant is never serviced.
REQ-011 SHALL time-share one N-bit down-counter among the 4 channels; at most one owner at a time.
REQ-012 Arbiter states: IDLE, COUNT. IDLE with >=1 request -> COUNT on the next edge; the grant loads the timer with all ones, sets owner and busy.
REQ-013 Grant selection SHALL be round-robin: first requesting channel at or after ptr, wrapping 3->0.
REQ-014 In COUNT, each edge with sw_s[owner] != db_level[owner] SHALL decrement the timer by 1.
REQ-015 On the edge where the timer reaches 0: db_level[owner] toggles, db_tick[owner]=1 for that cycle only if the new level is 1, busy=0, ptr=owner+1 mod 4, state -> IDLE.
REQ-016 In COUNT, an edge with sw_s[owner] == db_level[owner] SHALL abort: db_level unchanged, no tick, timer cleared, busy=0, ptr=owner+1 mod 4, state -> IDLE.
REQ-017 Level change latency SHALL be exactly 2^N-1 edges after the grant edge, given a stable input.
REQ-018 No grant SHALL occur on the release edge; the next grant is at the earliest on the following edge (1-cycle gap).
REQ-019 Non-owner channels SHALL hold db_level while waiting; requests are never lost, only deferred.
REQ-020 owner SHALL hold its value in IDLE.
REQ-021 At most one db_tick bit SHALL be high in any cycle.

Reset
REQ-022 On a rising edge with rst=0: db_level=0, db_tick=0, busy=0, owner=0, ptr=0, timer=0, synchronizer flops=0, state=IDLE.
REQ-023 Reset mid-COUNT SHALL abandon the count with no level change and no tick; reset wins over all other events on the same edge.

Configuration
REQ-024 Macro DB_SCAN_FALL_TICK_EN defined: adds output port db_fall  4  one-cycle pulse on debounced 1->0 transitions, same timing as db_tick, reset to 0.
REQ-025 Macro DB_SCAN_FALL_TICK_EN undefined: port db_fall and its logic are absent; all other behaviour is identical.

Verification (N=4, so count latency 15)
REQ-026 sw=4'hF held, rst=0 for 2 cycles -> all outputs 0; after rst=1, busy rises 3 edges later with owner=0.
REQ-027 Only sw[2]=1, held -> db_level[2] rises 15 edges after grant, db_tick[2] high exactly 1 cycle, busy falls on the same edge.
REQ-028 sw[1]=1 for 5 cycles after grant, then 0 -> abort, busy=0, db_level[1]=0, no tick, ptr=2.
REQ-029 sw 0->4'hF with ptr=0 -> grants in order ch0,1,2,3, db_level bits rise at 16-cycle spacing, one tick each.
REQ-030 rst=0 at timer=7 during ch3 count -> db_level[3]=0, busy=0, no tick; after release, ch0 is served first if it is requesting.
REQ-031 DB_SCAN_FALL_TICK_EN defined, ch0 level 1, sw[0]->0 held -> db_fall[0] pulses 1 cycle, db_tick stays 0.
